// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-lane inter-stage pipeline latch
// with in-order lane kill and saturating stall/flush counters.
//
// Ports:
//   clk, rst (async, active-low)
//   stall[STALL_W], flush        : control unit
//   in_lane_valid/kill[LANES]    : per-lane status
//   in_we[LANES*WE_W]            : write enables, lane l at [l*WE_W +: WE_W]
//   in_data[LANES*DATA_W]        : payload, lane l at [l*DATA_W +: DATA_W]
//   out_lane_valid/out_we/out_data : registered bundle
//   clr_cnt                      : synchronous counter clear
//   bubble_cnt/hold_cnt/flush_cnt : event counters
module pipe_stage_reg #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 32,
    parameter int WE_W    = 4,
    parameter int STALL_W = 5,
    parameter int STAGE   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES-1:0]        in_lane_kill,
    input  logic [LANES*WE_W-1:0]   in_we,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*WE_W-1:0]   out_we,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    clr_cnt,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        hold_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    logic up_stall;
    logic dn_stall;
    logic do_zero;
    logic do_bubble;
    logic do_hold;
    logic do_adv;

    assign up_stall  = stall[STAGE];
    assign dn_stall  = stall[STAGE+1];
    assign do_bubble = ~flush & up_stall & ~dn_stall;
    assign do_hold   = ~flush & up_stall & dn_stall;
    assign do_adv    = ~flush & ~up_stall;
    assign do_zero   = flush | do_bubble;

    // Lane 0 is oldest: a kill squashes itself and all younger lanes.
    logic [LANES-1:0] kill_eff;
    logic [LANES-1:0] acc_lane;

    always_comb begin
        logic k;
        k        = 1'b0;
        kill_eff = '0;
        for (int l = 0; l < LANES; l++) begin
            k           = k | in_lane_kill[l];
            kill_eff[l] = k;
        end
    end

    assign acc_lane = in_lane_valid & ~kill_eff;

    // Rejected lanes are zeroed so an invalid lane never
    // carries stray enables or data downstream.
    logic [LANES*WE_W-1:0]   nxt_we;
    logic [LANES*DATA_W-1:0] nxt_data;

    always_comb begin
        nxt_we   = '0;
        nxt_data = '0;
        for (int l = 0; l < LANES; l++) begin
            if (acc_lane[l]) begin
                nxt_we[l*WE_W +: WE_W]       = in_we[l*WE_W +: WE_W];
                nxt_data[l*DATA_W +: DATA_W] = in_data[l*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_lane_valid <= '0;
            out_we         <= '0;
            out_data       <= '0;
        end else if (do_zero) begin
            out_lane_valid <= '0;
            out_we         <= '0;
            out_data       <= '0;
        end else if (do_adv) begin
            out_lane_valid <= acc_lane;
            out_we         <= nxt_we;
            out_data       <= nxt_data;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c
    );
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
            flush_cnt  <= '0;
        end else if (clr_cnt) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
            flush_cnt  <= '0;
        end else begin
            if (flush)     flush_cnt  <= sat_inc(flush_cnt);
            if (do_bubble) bubble_cnt <= sat_inc(bubble_cnt);
            if (do_hold)   hold_cnt   <= sat_inc(hold_cnt);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_inv
        a_inv: assert property (
            @(posedge clk) disable iff (!rst)
            !out_lane_valid[l] |->
                (out_we[l*WE_W +: WE_W] == '0 &&
                 out_data[l*DATA_W +: DATA_W] == '0)
        );
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg
// (LANES=2, DATA_W=32, WE_W=4, STAGE=3, CNT_W=4).
module tb_pipe_stage_reg;

    localparam int CMAX = 15;

    logic        clk;
    logic        rst;
    logic [4:0]  stall;
    logic        flush;
    logic [1:0]  in_lane_valid;
    logic [1:0]  in_lane_kill;
    logic [7:0]  in_we;
    logic [63:0] in_data;
    logic [1:0]  out_lane_valid;
    logic [7:0]  out_we;
    logic [63:0] out_data;
    logic        clr_cnt;
    logic [3:0]  bubble_cnt;
    logic [3:0]  hold_cnt;
    logic [3:0]  flush_cnt;

    pipe_stage_reg #(
        .LANES(2), .DATA_W(32), .WE_W(4),
        .STALL_W(5), .STAGE(3), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_lane_valid(in_lane_valid),
        .in_lane_kill(in_lane_kill),
        .in_we(in_we), .in_data(in_data),
        .out_lane_valid(out_lane_valid),
        .out_we(out_we), .out_data(out_data),
        .clr_cnt(clr_cnt),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  v;
        logic [7:0]  we;
        logic [63:0] d;
        logic [3:0]  b;
        logic [3:0]  h;
        logic [3:0]  f;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the expected contents of the stage.
    logic [1:0]  m_v;
    logic [7:0]  m_we;
    logic [63:0] m_d;
    int          m_b, m_h, m_f;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_v = '0; m_we = '0; m_d = '0;
        m_b = 0;  m_h = 0;   m_f = 0;
    endtask

    task automatic model_step(input logic [4:0] s,
                              input logic fl,
                              input logic [1:0] v,
                              input logic [1:0] k,
                              input logic [7:0] we,
                              input logic [63:0] d,
                              input logic clr);
        bit up, dn, killed, ok;
        up = s[3];
        dn = s[4];
        if (fl || (up && !dn)) begin
            m_v = '0; m_we = '0; m_d = '0;
        end else if (!up) begin
            for (int l = 0; l < 2; l++) begin
                killed = 0;
                for (int j = 0; j <= l; j++)
                    if (k[j]) killed = 1;
                ok = v[l] && !killed;
                m_v[l]            = ok;
                m_we[l*4 +: 4]    = ok ? we[l*4 +: 4] : 4'h0;
                m_d[l*32 +: 32]   = ok ? d[l*32 +: 32] : 32'h0;
            end
        end
        if (clr) begin
            m_b = 0; m_h = 0; m_f = 0;
        end else if (fl) begin
            if (m_f < CMAX) m_f++;
        end else if (up && !dn) begin
            if (m_b < CMAX) m_b++;
        end else if (up && dn) begin
            if (m_h < CMAX) m_h++;
        end
    endtask

    task automatic drv(input logic [4:0] s,
                       input logic fl,
                       input logic [1:0] v,
                       input logic [1:0] k,
                       input logic [7:0] we,
                       input logic [63:0] d,
                       input logic clr);
        exp_t e;
        @(negedge clk);
        stall = s; flush = fl; in_lane_valid = v;
        in_lane_kill = k; in_we = we; in_data = d;
        clr_cnt = clr;
        model_step(s, fl, v, k, we, d, clr);
        e.v = m_v; e.we = m_we; e.d = m_d;
        e.b = 4'(m_b); e.h = 4'(m_h); e.f = 4'(m_f);
        q.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 64'(out_lane_valid), 64'h0);
        chk({nm, "_we"},    64'(out_we),         64'h0);
        chk({nm, "_data"},  out_data,            64'h0);
        chk({nm, "_cnts"},
            64'({bubble_cnt, hold_cnt, flush_cnt}), 64'h0);
    endtask

    // Monitor: one scoreboard entry per clock edge driven.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("valid",  64'(out_lane_valid), 64'(e.v));
            chk("we",     64'(out_we),         64'(e.we));
            chk("data",   out_data,            e.d);
            chk("bubble", 64'(bubble_cnt),     64'(e.b));
            chk("hold",   64'(hold_cnt),       64'(e.h));
            chk("flush",  64'(flush_cnt),      64'(e.f));
        end
    end

    localparam logic [4:0] S_ADV = 5'b00000;
    localparam logic [4:0] S_BUB = 5'b01000;
    localparam logic [4:0] S_HLD = 5'b11000;
    localparam logic [63:0] D1 = 64'hBBBB0002_AAAA0001;

    initial begin
        rst = 1'b0;
        stall = 5'h1F; flush = 1'b1; clr_cnt = 1'b1;
        in_lane_valid = 2'b11; in_lane_kill = 2'b00;
        in_we = 8'hFF; in_data = {$urandom, $urandom};
        model_reset();
        #2;
        chk_zero("reset0");
        sync();
        rst = 1'b1;

        drv(S_ADV, 0, 2'b11, 2'b00, 8'hF5, D1, 0);
        sync();
        chk("load_data", out_data, D1);
        chk("load_we", 64'(out_we), 64'hF5);

        drv(S_ADV, 0, 2'b11, 2'b01, 8'hF5, D1, 0);
        drv(S_ADV, 0, 2'b11, 2'b10, 8'hF5, D1, 0);
        sync();
        chk("kill_valid", 64'(out_lane_valid), 64'h1);
        chk("kill_data", out_data, 64'h00000000_AAAA0001);

        drv(S_BUB, 0, 2'b11, 2'b00, 8'h33, 64'h1111, 0);
        repeat (3)
            drv(S_HLD, 0, 2'b11, 2'b00, 8'h33, 64'h2222, 0);
        sync();
        chk("bub_hold_cnt", 64'(hold_cnt), 64'd3);
        chk("bub_bub_cnt", 64'(bubble_cnt), 64'd1);
        drv(S_ADV, 0, 2'b11, 2'b00, 8'h77, D1, 0);

        drv(S_ADV, 0, 2'b01, 2'b00, 8'h0F, 64'h12345678, 0);
        repeat (2)
            drv(S_HLD, 0, 2'b11, 2'b00, 8'hFF, 64'hDEAD, 0);
        sync();
        chk("hold_data", out_data, 64'h12345678);

        drv(S_BUB, 1, 2'b11, 2'b00, 8'hFF, D1, 0);
        sync();
        chk("flush_cnt1", 64'(flush_cnt), 64'd1);
        chk("flush_bub", 64'(bubble_cnt), 64'd1);

        repeat (20)
            drv(S_HLD, 0, 2'b11, 2'b00, 8'hFF, D1, 0);
        sync();
        chk("hold_sat", 64'(hold_cnt), 64'hF);
        drv(S_HLD, 0, 2'b11, 2'b00, 8'hFF, D1, 1);
        drv(S_ADV, 0, 2'b11, 2'b00, 8'hA5, D1, 0);
        sync();

        // Asynchronous reset mid-operation.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("reset_mid");
        model_reset();
        sync();
        rst = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [4:0] s;
            s    = 5'($urandom);
            s[3] = ($urandom_range(0, 9) < 4);
            drv(s,
                ($urandom_range(0, 15) == 0),
                2'($urandom),
                ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                8'($urandom),
                {$urandom, $urandom},
                ($urandom_range(0, 31) == 0));
        end

        for (int i = 0; i < 5 && q.size() > 0; i++)
            @(posedge clk);
        #2;
        chk("drain", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
